// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the fetch stage.
// Holds the IF/ID bundle, the NOP encoding and the fetch FSM states.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] Curr_Pc;
      logic [31:0] Curr_Instr;
   } if_id_reg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_ACK,
      WAIT_STALE
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if #(
   parameter int PC_W = 9
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instr} pairs for decode.
// Zero-cycle read of the head entry; flush empties it in one cycle.
module fetch_fifo #(
   parameter int WIDTH = 41,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage array: written on push, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset)
         mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; flush and reset clear them.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= nxt(wr_ptr);
         if (do_pop)
            rd_ptr <= nxt(rd_ptr);
         if (do_push && !do_pop)
            count <= count + 1'b1;
         else if (do_pop && !do_push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: pc register, single-outstanding request FSM and
// a small buffer feeding decode, with redirect flush and stale-ack drop.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int PC_W  = 9,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   fetch_stage_if.master   imem,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            stall,
   input  logic            halt,
   output if_id_reg        if_id,
   output logic            if_id_valid
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int W     = PC_W + 32;

   fetch_state_e    state;
   fetch_state_e    state_n;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_n;
   logic [PC_W-1:0] addr_q;
   logic [PC_W-1:0] addr_n;
   logic            req;
   logic            push;
   logic            pop;
   logic            flush;
   logic            can_issue;
   logic [W-1:0]    head;
   logic [CNT_W-1:0] count;
   logic            empty;

   assign flush     = redirect && !reset;
   assign pop       = !empty && !stall && !redirect && !reset;
   assign can_issue = (count < CNT_W'(DEPTH)) || pop;

   assign imem.imem_req  = req;
   assign imem.imem_addr = (state == IDLE) ? pc : addr_q;

   assign if_id_valid = !empty;
   assign if_id.Curr_Pc    = empty ? 32'h0 : 32'(head[W-1:32]);
   assign if_id.Curr_Instr = empty ? NOP_INSTR : head[31:0];

   fetch_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   ({addr_q, imem.imem_rdata}),
      .head  (head),
      .count (count),
      .empty (empty)
   );

   // State, pc and in-flight address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= '0;
         addr_q <= '0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         addr_q <= addr_n;
      end
   end

   // Next state, request strobe, push and pc update; redirect wins.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      addr_n  = addr_q;
      req     = 1'b0;
      push    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!redirect && !halt && can_issue) begin
               req     = 1'b1;
               addr_n  = pc;
               state_n = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            req = 1'b1;
            if (redirect) begin
               state_n = imem.imem_ack ? IDLE : WAIT_STALE;
            end else if (imem.imem_ack) begin
               push    = 1'b1;
               pc_n    = pc + PC_W'(4);
               state_n = IDLE;
            end
         end
         WAIT_STALE: begin
            req = 1'b1;
            if (imem.imem_ack)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (redirect)
         pc_n = redirect_pc & ~PC_W'(3);
      if (reset) begin
         req  = 1'b0;
         push = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Memory model acks a held request after a programmable latency.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam int PC_W  = 9;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic            stall;
   logic            halt;
   if_id_reg        if_id;
   logic            if_id_valid;

   logic        mem_en;
   logic        man_ack;
   logic [31:0] man_data;
   int          lat;
   int          cnt = 0;

   int tests = 0;
   int fails = 0;

   fetch_stage_if #(.PC_W(PC_W)) imem ();

   fetch_stage #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (imem),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .halt        (halt),
      .if_id       (if_id),
      .if_id_valid (if_id_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset || !imem.imem_req || imem.imem_ack)
         cnt <= 0;
      else
         cnt <= cnt + 1;
   end

   assign imem.imem_ack = mem_en ? (imem.imem_req && cnt == lat) : man_ack;
   assign imem.imem_rdata = mem_en ?
      (32'hA000_0000 | 32'(imem.imem_addr)) : man_data;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      cyc;
      cyc;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      if_id_reg e;
      reset = 1'b1;
      cyc;
      @(negedge clk);
      e = '{Curr_Pc: 32'h0, Curr_Instr: NOP_INSTR};
      tests++;
      if (imem.imem_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_req got %b want 0", imem.imem_req);
      end
      tests++;
      if (if_id_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_valid got %b want 0", if_id_valid);
      end
      tests++;
      if (if_id !== e) begin
         fails++;
         $display("FAIL reset_if_id got %h want %h", if_id, e);
      end
   endtask

   task automatic test_straight;
      logic     ev;
      if_id_reg e;
      stall = 1'b0;
      halt  = 1'b0;
      lat   = 1;
      do_reset;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) cyc;
         @(negedge clk);
         if (i == 0) begin
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h000) begin
               fails++;
               $display("FAIL first_req got %b/%h want 1/000",
                        imem.imem_req, imem.imem_addr);
            end
         end
         ev = (i >= 2) && (i % 2 == 0);
         tests++;
         if (if_id_valid !== ev) begin
            fails++;
            $display("FAIL straight_valid c%0d got %b want %b",
                     i, if_id_valid, ev);
         end
         if (ev) begin
            e.Curr_Pc    = 32'((i - 2) * 2);
            e.Curr_Instr = 32'hA000_0000 | e.Curr_Pc;
            tests++;
            if (if_id !== e) begin
               fails++;
               $display("FAIL straight_if_id c%0d got %h want %h",
                        i, if_id, e);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int       ep [11] = '{-1, -1, 0, 0, 0, 0, 0, 4, 8, -1, 12};
      if_id_reg e;
      stall = 1'b1;
      lat   = 1;
      do_reset;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) cyc;
         stall = (i < 6);
         @(negedge clk);
         tests++;
         if (if_id_valid !== (ep[i] >= 0)) begin
            fails++;
            $display("FAIL bp_valid c%0d got %b want %b",
                     i, if_id_valid, ep[i] >= 0);
         end
         if (ep[i] >= 0) begin
            e.Curr_Pc    = 32'(ep[i]);
            e.Curr_Instr = 32'hA000_0000 | e.Curr_Pc;
            tests++;
            if (if_id !== e) begin
               fails++;
               $display("FAIL bp_if_id c%0d got %h want %h", i, if_id, e);
            end
         end
         if (i == 4 || i == 5) begin
            tests++;
            if (dut.count !== 2'd2 || imem.imem_req !== 1'b0) begin
               fails++;
               $display("FAIL bp_full c%0d got cnt %0d req %b want 2 0",
                        i, dut.count, imem.imem_req);
            end
         end
         if (i == 6) begin
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h008) begin
               fails++;
               $display("FAIL bp_resume got %b/%h want 1/008",
                        imem.imem_req, imem.imem_addr);
            end
         end
      end
   endtask

   task automatic test_stale_ack;
      int ep [13] = '{-1, -1, 0, -1, 4, -1, -1, -1, -1, -1, -1, -1, 'h40};
      if_id_reg e;
      stall = 1'b0;
      lat   = 1;
      do_reset;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) cyc;
         if (i == 4) lat = 3;
         redirect    = (i == 5);
         redirect_pc = 9'h040;
         @(negedge clk);
         tests++;
         if (if_id_valid !== (ep[i] >= 0)) begin
            fails++;
            $display("FAIL stale_valid c%0d got %b want %b",
                     i, if_id_valid, ep[i] >= 0);
         end
         if (ep[i] >= 0) begin
            e.Curr_Pc    = 32'(ep[i]);
            e.Curr_Instr = 32'hA000_0000 | e.Curr_Pc;
            tests++;
            if (if_id !== e) begin
               fails++;
               $display("FAIL stale_if_id c%0d got %h want %h", i, if_id, e);
            end
         end
         if (i == 6) begin
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h008) begin
               fails++;
               $display("FAIL stale_hold got %b/%h want 1/008",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (i == 8) begin
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h040) begin
               fails++;
               $display("FAIL stale_newreq got %b/%h want 1/040",
                        imem.imem_req, imem.imem_addr);
            end
         end
      end
      redirect = 1'b0;
      lat      = 1;
   endtask

   task automatic test_same_cycle;
      if_id_reg e;
      stall = 1'b0;
      lat   = 1;
      do_reset;
      for (int i = 0; i < 7; i++) begin
         if (i > 0) cyc;
         stall       = (i == 2);
         redirect    = (i == 3);
         redirect_pc = 9'h013;
         @(negedge clk);
         if (i == 4) begin
            tests++;
            if (if_id_valid !== 1'b0 || dut.count !== 2'd0) begin
               fails++;
               $display("FAIL same_flush got v %b cnt %0d want 0 0",
                        if_id_valid, dut.count);
            end
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h010) begin
               fails++;
               $display("FAIL same_mask got %b/%h want 1/010",
                        imem.imem_req, imem.imem_addr);
            end
         end
         if (i == 5) begin
            tests++;
            if (if_id_valid !== 1'b0) begin
               fails++;
               $display("FAIL same_gap got %b want 0", if_id_valid);
            end
         end
         if (i == 6) begin
            e = '{Curr_Pc: 32'h10, Curr_Instr: 32'hA000_0010};
            tests++;
            if (if_id_valid !== 1'b1 || if_id !== e) begin
               fails++;
               $display("FAIL same_next got %b %h want 1 %h",
                        if_id_valid, if_id, e);
            end
         end
      end
      redirect = 1'b0;
   endtask

   task automatic test_wrap_halt;
      int ep [11] = '{-1, -1, -1, 'h1FC, -1, 0, -1, -1, 4, -1, -1};
      int er [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
      int ea [11] = '{-1, 'h1FC, 'h1FC, 0, 0, 4, 4, 4, -1, -1, -1};
      if_id_reg e;
      stall = 1'b0;
      halt  = 1'b1;
      lat   = 1;
      do_reset;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) cyc;
         redirect    = (i == 0);
         redirect_pc = 9'h1FC;
         halt        = (i == 0) || (i >= 6);
         if (i == 5) lat = 2;
         @(negedge clk);
         tests++;
         if (imem.imem_req !== er[i][0]) begin
            fails++;
            $display("FAIL wh_req c%0d got %b want %b",
                     i, imem.imem_req, er[i][0]);
         end
         if (ea[i] >= 0) begin
            tests++;
            if (imem.imem_addr !== PC_W'(ea[i])) begin
               fails++;
               $display("FAIL wh_addr c%0d got %h want %h",
                        i, imem.imem_addr, PC_W'(ea[i]));
            end
         end
         tests++;
         if (if_id_valid !== (ep[i] >= 0)) begin
            fails++;
            $display("FAIL wh_valid c%0d got %b want %b",
                     i, if_id_valid, ep[i] >= 0);
         end
         if (ep[i] >= 0) begin
            e.Curr_Pc    = 32'(ep[i]);
            e.Curr_Instr = 32'hA000_0000 | e.Curr_Pc;
            tests++;
            if (if_id !== e) begin
               fails++;
               $display("FAIL wh_if_id c%0d got %h want %h", i, if_id, e);
            end
         end
      end
      halt = 1'b0;
      lat  = 1;
   endtask

   task automatic test_reset_mid;
      if_id_reg e;
      stall = 1'b0;
      halt  = 1'b0;
      lat   = 3;
      do_reset;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) cyc;
         reset    = (i == 1);
         halt     = (i == 2);
         mem_en   = (i != 2);
         man_ack  = (i == 2);
         man_data = 32'hDEAD_BEEF;
         if (i == 3) lat = 1;
         @(negedge clk);
         if (i == 1 || i == 2) begin
            tests++;
            if (imem.imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
               fails++;
               $display("FAIL rm_idle c%0d got req %b v %b want 0 0",
                        i, imem.imem_req, if_id_valid);
            end
         end
         if (i == 3) begin
            tests++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 9'h000 ||
                if_id_valid !== 1'b0) begin
               fails++;
               $display("FAIL rm_restart got %b/%h v %b want 1/000 v 0",
                        imem.imem_req, imem.imem_addr, if_id_valid);
            end
         end
         if (i == 4) begin
            tests++;
            if (if_id_valid !== 1'b0) begin
               fails++;
               $display("FAIL rm_late_ack got v %b want 0", if_id_valid);
            end
         end
         if (i == 5) begin
            e = '{Curr_Pc: 32'h0, Curr_Instr: 32'hA000_0000};
            tests++;
            if (if_id_valid !== 1'b1 || if_id !== e) begin
               fails++;
               $display("FAIL rm_first got %b %h want 1 %h",
                        if_id_valid, if_id, e);
            end
         end
      end
      mem_en  = 1'b1;
      man_ack = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;
      halt        = 1'b0;
      mem_en      = 1'b1;
      man_ack     = 1'b0;
      man_data    = '0;
      lat         = 1;
      test_reset;
      test_straight;
      test_backpressure;
      test_stale_ack;
      test_same_cycle;
      test_wrap_halt;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
